// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-capable arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional WRARB_STALL_CNT_EN adds a saturating stall_cnt output counting cycles blocked by w_full.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          write_clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          w_full,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
`ifdef WRARB_STALL_CNT_EN
  output logic                          busy,
  output logic [15:0]                   stall_cnt
`else
  output logic                          busy
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, rr_nx, owner, owner_nx, sel, cur, idx;
  logic [CW-1:0] cnt, cnt_nx;
  logic beat;
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return x == IW'(NUM_REQ - 1) ? '0 : x + IW'(1);
  endfunction
  // Descending scan so the requester closest above rr_ptr wins.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[idx]) sel = idx;
    end
  end
  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    owner_nx = owner;
    cnt_nx   = cnt;
    cur      = state == BURST ? owner : sel;
    beat     = reset_n && req[cur] && !w_full;
    if (state == IDLE) begin
      if (beat) begin
        if (last[cur] || MAX_BURST == 1) rr_nx = inc(cur);
        else begin
          state_nx = BURST;
          owner_nx = cur;
          cnt_nx   = CW'(1);
        end
      end
    end else if (!req[owner] || (beat && (last[owner] || cnt + CW'(1) == CW'(MAX_BURST)))) begin
      state_nx = IDLE;
      rr_nx    = inc(owner);
      cnt_nx   = '0;
    end else if (beat) cnt_nx = cnt + CW'(1);
  end
  // Outputs are gated by reset_n so they fall the instant reset asserts.
  assign ack      = beat ? {{(NUM_REQ-1){1'b0}}, 1'b1} << cur : '0;
  assign w_en     = beat;
  assign w_data   = beat ? data[cur*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign grant_id = reset_n ? cur : '0;
  assign busy     = reset_n && state == BURST;
  always_ff @(posedge write_clk or negedge reset_n)
    if (!reset_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      rr_ptr <= rr_nx;
      owner  <= owner_nx;
      cnt    <= cnt_nx;
    end
`ifdef WRARB_STALL_CNT_EN
  always_ff @(posedge write_clk or negedge reset_n)
    if (!reset_n) stall_cnt <= '0;
    else if (|req && w_full && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`else
`endif
endmodule
